sobel_frame_controller: RTL and testbench
=========================================

# sobel_frame_controller

Frame sequencer between the UART receive path and the Sobel line-buffer datapath. Buffers and validates the 4-byte image header before the datapath sees it, then forwards pixels, generates trailing flush strobes to retire the last row, and counts filtered output bytes to detect frame completion. Faults hold the datapath in reset and are reported until software clears them: bad dimensions, stalls, and bytes arriving while the controller is generating its own.

## Interface
- MAX_WIDTH, 1024: largest accepted image width; must not exceed the line-buffer depth.
- MAX_HEIGHT, 4096: largest accepted image height.
- BYTE_GAP, 16: minimum cycles between controller-generated dp_valid strobes (header replay and flush); ≥2.
- TIMEOUT_CYCLES, 2_000_000: stall limit, in cycles.
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from UART RX.
- rx_valid  in  1  one-cycle strobe, rx_data valid; strobes ≥2 cycles apart.
- dp_data  out  8  byte to datapath data_in.
- dp_valid  out  1  one-cycle strobe to datapath valid_in.
- dp_rst  out  1  active-high synchronous reset to the datapath.
- dp_out_valid  in  1  datapath valid_out; each high cycle is one output byte.
- clear_err  in  1  one-cycle pulse; leaves ERROR.
- busy  out  1  high in every state except IDLE and ERROR.
- frame_done  out  1  one-cycle pulse on successful frame completion.
- err_code  out  2  0 none, 1 bad dimension, 2 timeout, 3 overrun; sticky until clear_err.
- out_count  out  32  output bytes counted in the current or last frame.

## Operation
- Header is little-endian width, then height. Pixel count is P = width*height; both the product and all counters are 32-bit unsigned.
- States:
  - IDLE: dp_rst=0. First rx_valid captures width[7:0]; go to HDR. out_count clears on entry to HDR.
  - HDR: capture the remaining 3 header bytes in order; nothing is forwarded. After the 4th byte go to CHECK.
  - CHECK (1 cycle): fault if width==0, height==0, width>MAX_WIDTH or height>MAX_HEIGHT. On fault set err_code=1 and go to ERROR. Otherwise load pix_left=P and go to HDR_TX.
  - HDR_TX: replay the 4 header bytes, in the order received, as dp_valid strobes spaced exactly BYTE_GAP cycles apart, first strobe the cycle after CHECK. Then go to PIXELS.
  - PIXELS: each rx_valid is registered to dp_data/dp_valid and pix_left decrements. When pix_left reaches 0, go to FLUSH.
  - FLUSH: emit width+1 strobes with dp_data=0x00, spaced BYTE_GAP cycles, first strobe BYTE_GAP cycles after the last pixel strobe. Then go to DRAIN.
  - DRAIN: when out_count==P, pulse frame_done and go to IDLE.
  - ERROR: dp_rst=1, dp_valid=0, rx ignored. On clear_err, set err_code=0 and go to IDLE.
- out_count increments on every dp_out_valid cycle in HDR_TX, PIXELS, FLUSH and DRAIN. It saturates at 2^32−1.
- Overrun: rx_valid in HDR_TX, FLUSH or DRAIN drops the byte, sets err_code=3 and goes to ERROR.
- Timeout: a stall counter runs in HDR, PIXELS and DRAIN. It resets on any rx_valid or dp_out_valid and on every state change. When it reaches TIMEOUT_CYCLES, set err_code=2 and go to ERROR.
- Precedence within one cycle: overrun > timeout > normal transition.
- clear_err outside ERROR has no effect.

## Timing
- Reset values: dp_data=0x00, dp_valid=0, dp_rst=1, busy=0, frame_done=0, err_code=0, out_count=0; state=IDLE.
- dp_rst deasserts on the first clock edge after rst_n rises.
- Pixel latency: rx_valid at cycle n produces dp_valid at n+1, with dp_data equal to the rx_data sampled at n.
- Generated strobes are exactly 1 cycle wide and exactly BYTE_GAP apart.
- frame_done rises the cycle after the dp_out_valid that makes out_count reach P. busy falls in the same cycle.
- CHECK→ERROR takes 1 cycle after the 4th header byte. err_code is visible the same cycle ERROR is entered.
- rst_n asserted mid-frame: all outputs return to reset values immediately (asynchronously), not at the next clock edge.
- A new frame's first byte is accepted the cycle after frame_done.

## Test plan
- Nominal frame, width=4 height=3, BYTE_GAP=4: header 04 00 03 00 plus 12 pixels at 8-cycle spacing; model datapath returns 12 dp_out_valid → 4 header strobes 4 cycles apart, 12 forwarded pixels each 1 cycle late, 5 strobes of 0x00, out_count=12, single frame_done pulse, err_code=0.
- Bad dimension: header 00 00 03 00 (width 0), then header 01 04 01 00 (width 1025) → ERROR after 4th byte, err_code=1, zero dp_valid strobes, dp_rst=1; clear_err → IDLE, dp_rst=0.
- Timeout: valid 4x3 header, 5 pixels, then silence for TIMEOUT_CYCLES → err_code=2 exactly TIMEOUT_CYCLES cycles after the last pixel, dp_rst=1.
- Overrun: rx_valid during FLUSH of a 2x2 frame → byte dropped, no extra dp_valid, err_code=3.
- Async reset in PIXELS: pulse rst_n low between clock edges → dp_rst=1, busy=0, out_count=0 before the next edge; a subsequent clean 2x2 frame completes with frame_done.
- Back-to-back frames: 2x2 then 3x1, first header byte arriving 1 cycle after frame_done → both complete; out_count=4 then 3.

Source files
------------

// File: rtl/sobel_frame_controller.sv
// Frame sequencer between UART RX and the Sobel line-buffer datapath: validates and
// replays the image header, forwards pixels, flushes the last row and tracks completion.
module sobel_frame_controller #(
    parameter int MAX_WIDTH      = 1024,
    parameter int MAX_HEIGHT     = 4096,
    parameter int BYTE_GAP       = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  dp_data,
    output logic        dp_valid,
    output logic        dp_rst,
    input  logic        dp_out_valid,
    input  logic        clear_err,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  err_code,
    output logic [31:0] out_count
);

    localparam int GAP_W   = $clog2(BYTE_GAP);
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0]   GAP_RELOAD  = GAP_W'(BYTE_GAP - 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MAX_W32 = 32'(MAX_WIDTH);
    localparam logic [31:0] MAX_H32 = 32'(MAX_HEIGHT);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DIM     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CHECK,
        S_HDR_TX,
        S_PIXELS,
        S_FLUSH,
        S_DRAIN,
        S_ERROR
    } state_t;

    state_t              state_reg;
    logic [1:0]          byte_idx_reg;
    logic [31:0]         pix_total_reg;
    logic [31:0]         pix_left_reg;
    logic [16:0]         flush_left_reg;
    logic [GAP_W-1:0]    gap_reg;
    logic [STALL_W-1:0]  stall_reg;
    logic [7:0]          hdr_byte [4];

    logic [15:0] width;
    logic [15:0] height;
    logic [31:0] width32;
    logic [31:0] height32;
    logic [31:0] frame_pixels;
    logic        dims_bad;
    logic        counting_out;
    logic [31:0] out_count_next;
    logic        stall_state;
    logic        stall_hit;
    logic        overrun;
    logic        gap_due;
    logic [1:0]  fault_code;

    // Header bytes land in separate registers so the replay can index them directly.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hdr
            logic [7:0] byte_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    byte_reg <= 8'h00;
                end else if (rx_valid &&
                             ((state_reg == S_IDLE && gi == 0) ||
                              (state_reg == S_HDR && byte_idx_reg == 2'(gi)))) begin
                    byte_reg <= rx_data;
                end
            end
            assign hdr_byte[gi] = byte_reg;
        end
    endgenerate

    assign width        = {hdr_byte[1], hdr_byte[0]};
    assign height       = {hdr_byte[3], hdr_byte[2]};
    assign width32      = {16'd0, width};
    assign height32     = {16'd0, height};
    assign frame_pixels = width32 * height32;
    assign dims_bad     = (width == 16'd0) || (height == 16'd0) ||
                          (width32 > MAX_W32) || (height32 > MAX_H32);

    assign counting_out = dp_out_valid &&
                          (state_reg == S_HDR_TX || state_reg == S_PIXELS ||
                           state_reg == S_FLUSH  || state_reg == S_DRAIN);
    assign out_count_next = (counting_out && out_count != 32'hFFFF_FFFF) ?
                            out_count + 32'd1 : out_count;

    assign stall_state = (state_reg == S_HDR || state_reg == S_PIXELS || state_reg == S_DRAIN);
    assign stall_hit   = stall_state && !rx_valid && !dp_out_valid && (stall_reg == STALL_LIMIT);
    assign overrun     = rx_valid &&
                         (state_reg == S_HDR_TX || state_reg == S_FLUSH || state_reg == S_DRAIN);
    assign gap_due     = (gap_reg == '0);

    // Fault priority: overrun beats timeout beats the dimension check.
    always_comb begin
        fault_code = ERR_NONE;
        if (overrun) begin
            fault_code = ERR_OVERRUN;
        end else if (stall_hit) begin
            fault_code = ERR_TIMEOUT;
        end else if (state_reg == S_CHECK && dims_bad) begin
            fault_code = ERR_DIM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            dp_data        <= 8'h00;
            dp_valid       <= 1'b0;
            dp_rst         <= 1'b1;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            err_code       <= ERR_NONE;
            out_count      <= 32'd0;
            byte_idx_reg   <= 2'd0;
            pix_total_reg  <= 32'd0;
            pix_left_reg   <= 32'd0;
            flush_left_reg <= 17'd0;
            gap_reg        <= '0;
            stall_reg      <= '0;
        end else begin
            dp_valid   <= 1'b0;
            frame_done <= 1'b0;
            out_count  <= out_count_next;
            // Non-stall states park the counter at zero, so every state change restarts it.
            stall_reg  <= (stall_state && !rx_valid && !dp_out_valid) ? stall_reg + 1'b1 : '0;
            if (!gap_due) begin
                gap_reg <= gap_reg - 1'b1;
            end

            if (fault_code != ERR_NONE) begin
                state_reg <= S_ERROR;
                err_code  <= fault_code;
                dp_rst    <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        dp_rst <= 1'b0;
                        if (rx_valid) begin
                            state_reg    <= S_HDR;
                            busy         <= 1'b1;
                            byte_idx_reg <= 2'd1;
                            out_count    <= 32'd0;
                        end
                    end
                    S_HDR: begin
                        if (rx_valid) begin
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                            if (byte_idx_reg == 2'd3) begin
                                state_reg <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        pix_total_reg <= frame_pixels;
                        pix_left_reg  <= frame_pixels;
                        dp_valid      <= 1'b1;
                        dp_data       <= hdr_byte[0];
                        byte_idx_reg  <= 2'd1;
                        gap_reg       <= GAP_RELOAD;
                        state_reg     <= S_HDR_TX;
                    end
                    S_HDR_TX: begin
                        if (gap_due) begin
                            dp_valid     <= 1'b1;
                            dp_data      <= hdr_byte[byte_idx_reg];
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                            gap_reg      <= GAP_RELOAD;
                            if (byte_idx_reg == 2'd3) begin
                                state_reg <= S_PIXELS;
                            end
                        end
                    end
                    S_PIXELS: begin
                        if (rx_valid) begin
                            dp_valid     <= 1'b1;
                            dp_data      <= rx_data;
                            pix_left_reg <= pix_left_reg - 32'd1;
                            if (pix_left_reg == 32'd1) begin
                                state_reg      <= S_FLUSH;
                                gap_reg        <= GAP_RELOAD;
                                flush_left_reg <= {1'b0, width} + 17'd1;
                            end
                        end
                    end
                    S_FLUSH: begin
                        if (gap_due) begin
                            dp_valid       <= 1'b1;
                            dp_data        <= 8'h00;
                            flush_left_reg <= flush_left_reg - 17'd1;
                            gap_reg        <= GAP_RELOAD;
                            if (flush_left_reg == 17'd1) begin
                                state_reg <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        // Look one count ahead so frame_done follows the final output byte directly.
                        if (out_count == pix_total_reg || out_count_next == pix_total_reg) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state_reg  <= S_IDLE;
                        end
                    end
                    S_ERROR: begin
                        dp_rst <= 1'b1;
                        if (clear_err) begin
                            err_code  <= ERR_NONE;
                            dp_rst    <= 1'b0;
                            state_reg <= S_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sobel_frame_controller.sv
// Directed-sequence bench with randomized pixel data and spacing; the expected byte
// stream for each frame is built from header + pixels + (width+1) zero bytes.
module tb_sobel_frame_controller;

    localparam int G = 4;
    localparam int T = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        dp_out_valid = 1'b0;
    logic        clear_err = 1'b0;
    logic [7:0]  dp_data;
    logic        dp_valid;
    logic        dp_rst;
    logic        busy;
    logic        frame_done;
    logic [1:0]  err_code;
    logic [31:0] out_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fd_count = 0;
    int last_pix_cyc = 0;
    logic [7:0] cap_data[$];
    int         cap_cyc[$];
    logic [7:0] exp_q[$];

    sobel_frame_controller #(
        .MAX_WIDTH(1024),
        .MAX_HEIGHT(4096),
        .BYTE_GAP(G),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .dp_data(dp_data),
        .dp_valid(dp_valid),
        .dp_rst(dp_rst),
        .dp_out_valid(dp_out_valid),
        .clear_err(clear_err),
        .busy(busy),
        .frame_done(frame_done),
        .err_code(err_code),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (dp_valid === 1'b1) begin
            cap_data.push_back(dp_data);
            cap_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) fd_count = fd_count + 1;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_caps(input int n, input string tag);
        int k;
        k = 0;
        while (cap_data.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(tag, cap_data.size(), n);
    endtask

    task automatic clear_error();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("clear_err_code", err_code, 0);
        check("clear_dp_rst", dp_rst, 0);
        check("clear_busy", busy, 0);
    endtask

    task automatic start_frame(input int w, input int h);
        logic [7:0] hb[4];
        int c4;
        hb[0] = w[7:0];
        hb[1] = w[15:8];
        hb[2] = h[7:0];
        hb[3] = h[15:8];
        cap_data.delete();
        cap_cyc.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(hb[i]);
            send_rx(hb[i]);
            if (i == 0) check("busy_hdr", busy, 1);
            if (i < 3) @(negedge clk);
        end
        c4 = cyc;
        wait_caps(4, "hdr_strobes");
        check("hdr_first_latency", cap_cyc[0], c4 + 1);
    endtask

    task automatic send_pixels(input int w, input int n, input int fixed_gap);
        logic [7:0] px;
        int gap;
        for (int i = 0; i < n; i++) begin
            px = 8'($urandom);
            exp_q.push_back(px);
            @(negedge clk);
            rx_data      = px;
            rx_valid     = 1'b1;
            dp_out_valid = (i >= w);
            @(negedge clk);
            rx_valid     = 1'b0;
            dp_out_valid = 1'b0;
            last_pix_cyc = cyc;
            check("pix_valid", dp_valid, 1);
            check("pix_data", dp_data, px);
            gap = (fixed_gap > 0) ? fixed_gap : int'($urandom_range(2, 6));
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic finish_frame(input int w, input int h);
        int p;
        int fd0;
        int mism;
        int sp;
        p   = w * h;
        fd0 = fd_count;
        for (int z = 0; z <= w; z++) exp_q.push_back(8'h00);
        wait_caps(4 + p + w + 1, "all_strobes");
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= cap_data.size() || cap_data[i] !== exp_q[i]) mism++;
        end
        check("stream_bytes", mism, 0);
        sp = 0;
        if (cap_cyc.size() < exp_q.size()) begin
            sp++;
        end else begin
            for (int i = 1; i < 4; i++)
                if (cap_cyc[i] - cap_cyc[i-1] != G) sp++;
            for (int i = 4 + p; i <= 4 + p + w; i++)
                if (cap_cyc[i] - cap_cyc[i-1] != G) sp++;
        end
        check("strobe_spacing", sp, 0);
        for (int j = 0; j < w; j++) begin
            @(negedge clk);
            dp_out_valid = 1'b1;
            @(negedge clk);
            dp_out_valid = 1'b0;
            if (j < w - 1) begin
                check("no_early_done", frame_done, 0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        check("frame_done", frame_done, 1);
        check("busy_after_done", busy, 0);
        check("out_count", out_count, p);
        check("err_none", err_code, 0);
        check("done_pulses", fd_count - fd0, 1);
    endtask

    task automatic run_frame(input int w, input int h, input int fixed_gap);
        start_frame(w, h);
        send_pixels(w, w * h, fixed_gap);
        finish_frame(w, h);
    endtask

    task automatic bad_header(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] hb[4];
        hb[0] = b0;
        hb[1] = b1;
        hb[2] = b2;
        hb[3] = b3;
        cap_data.delete();
        cap_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            send_rx(hb[i]);
            if (i < 3) @(negedge clk);
        end
        check("check_state_err", err_code, 0);
        @(negedge clk);
        check("baddim_err", err_code, 1);
        check("baddim_dp_rst", dp_rst, 1);
        check("baddim_busy", busy, 0);
        check("baddim_no_strobe", cap_data.size(), 0);
        clear_error();
    endtask

    initial begin
        int k;
        int n;
        int hbad;
        int wgood;

        repeat (3) @(negedge clk);
        check("rst_dp_data", dp_data, 0);
        check("rst_dp_valid", dp_valid, 0);
        check("rst_dp_rst", dp_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err_code", err_code, 0);
        check("rst_out_count", out_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("dp_rst_release", dp_rst, 0);

        // Nominal 4x3 frame with 8-cycle pixel spacing.
        run_frame(4, 3, 8);
        @(negedge clk);
        check("done_single_cycle", frame_done, 0);

        // Bad dimensions: width 0, width 1025, random oversize height.
        bad_header(8'h00, 8'h00, 8'h03, 8'h00);
        bad_header(8'h01, 8'h04, 8'h01, 8'h00);
        hbad  = int'($urandom_range(4097, 65535));
        wgood = int'($urandom_range(1, 1024));
        bad_header(wgood[7:0], wgood[15:8], hbad[7:0], hbad[15:8]);

        // Timeout after 5 pixels of a 4x3 frame.
        start_frame(4, 3);
        send_pixels(4, 5, 0);
        k = 0;
        while (err_code !== 2'd2 && k < 3 * T) begin
            @(negedge clk);
            k++;
        end
        check("timeout_latency", cyc - last_pix_cyc, T);
        check("timeout_err", err_code, 2);
        check("timeout_dp_rst", dp_rst, 1);
        clear_error();

        // Overrun during the flush of a 2x2 frame.
        start_frame(2, 2);
        send_pixels(2, 4, 0);
        wait_caps(9, "flush_first");
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_rx(8'($urandom));
        check("overrun_err", err_code, 3);
        check("overrun_dp_rst", dp_rst, 1);
        check("overrun_dp_valid", dp_valid, 0);
        n = cap_data.size();
        repeat (2 * G) @(negedge clk);
        check("overrun_no_strobe", cap_data.size(), 9);
        check("overrun_stable", cap_data.size(), n);
        clear_error();

        // Asynchronous reset pulse in the middle of PIXELS.
        start_frame(2, 2);
        send_pixels(2, 3, 0);
        check("pre_rst_count", out_count, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_dp_rst", dp_rst, 1);
        check("async_busy", busy, 0);
        check("async_out_count", out_count, 0);
        check("async_dp_valid", dp_valid, 0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("async_release", dp_rst, 0);
        run_frame(2, 2, 0);

        // Back-to-back frames; the next header starts one cycle after frame_done.
        run_frame(2, 2, 0);
        run_frame(3, 1, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
